// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver: start, LSB-first data, optional even parity, stop.
// Good frames load a single-entry output register with valid/ready handshake.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Din,
  output logic [DATA_W-1:0] Dout,
  output logic              Dvalid,
  input  logic              Dready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] payload;
  logic              bad_par;
  logic              last_bit;
  logic              in_stop;
  logic              good;
  logic              load;
  logic              take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    last_bit = (cnt == CW'(DATA_W - 1));
    in_stop  = (state == STOP);
    case (state)
      IDLE:    if (!Din) state_nx = DATA;
      DATA:    if (last_bit) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  state_nx = STOP;
      STOP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    take = Dvalid & Dready;
    good = in_stop & Din & ~bad_par;
    // The output register is free if empty or being drained on this same edge.
    load = good & (~Dvalid | Dready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      payload    <= '0;
      bad_par    <= 1'b0;
      Dout       <= '0;
      Dvalid     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bad_par <= 1'b0;
        end
        DATA: begin
          payload[cnt] <= Din;
          cnt          <= cnt + 1'b1;
        end
        PARITY:  bad_par <= (^payload) ^ Din;
        default: ;
      endcase
      // A bad stop bit takes precedence, so at most one error pulses per frame.
      frame_err  <= in_stop & ~Din;
      parity_err <= in_stop & Din & bad_par;
      overrun    <= good & Dvalid & ~Dready;
      if (load) begin
        Dout   <= payload;
        Dvalid <= 1'b1;
      end else if (take) begin
        Dvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - scoreboard bench for serial_frame_rx with a frame-level reference model.
module tb_serial_frame_rx;

  localparam int K_ACC = 0, K_PERR = 1, K_FERR = 2, K_OVR = 3;
  localparam int EV_NONE = 0, EV_GOOD = 1, EV_PERR = 2, EV_FERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Din = 1'b1;
  logic       Dready = 1'b0;
  logic [7:0] Dout;
  logic       Dvalid, parity_err, frame_err, overrun;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .Din(Din), .Dout(Dout), .Dvalid(Dvalid),
    .Dready(Dready), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  bit         done = 1'b0;

  task automatic push(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One line cycle; the model advances at frame granularity via ev.
  task automatic cycle(input logic din, input logic rdy, input logic r, input int ev,
                       input logic [7:0] d);
    @(posedge clk);
    #1;
    Din    = din;
    Dready = rdy;
    rst    = r;
    if (r) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
    end
    exp_valid = m_valid;
    exp_data  = m_data;
    if (!r) begin
      if (m_valid && rdy) begin
        push(K_ACC, m_data);
        m_valid = 1'b0;
      end
      case (ev)
        EV_FERR: push(K_FERR, 8'h00);
        EV_PERR: push(K_PERR, 8'h00);
        EV_GOOD: begin
          if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = d;
          end else begin
            push(K_OVR, 8'h00);
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic pick_rdy(input bit rnd);
    return rnd ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stopb,
                            input int gap, input bit rnd, input logic srdy);
    int   ev;
    logic sr;
    cycle(1'b0, pick_rdy(rnd), 1'b0, EV_NONE, 8'h00);
    for (int i = 0; i < 8; i++) cycle(d[i], pick_rdy(rnd), 1'b0, EV_NONE, 8'h00);
    cycle((^d) ^ flip, pick_rdy(rnd), 1'b0, EV_NONE, 8'h00);
    ev = !stopb ? EV_FERR : (flip ? EV_PERR : EV_GOOD);
    sr = rnd ? pick_rdy(1'b1) : srdy;
    cycle(stopb, sr, 1'b0, ev, d);
    for (int g = 0; g < gap; g++) cycle(1'b1, pick_rdy(rnd), 1'b0, EV_NONE, 8'h00);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, rdy, 1'b0, EV_NONE, 8'h00);
  endtask

  task automatic pop_check(input int kind, input logic [7:0] d, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event kind %0d data %h, expected nothing", name, kind, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_ACC && e.data != d)) begin
        errors++;
        $display("FAIL %s: got kind %0d data %h, expected kind %0d data %h",
                 name, kind, d, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      checks++;
      if (Dvalid !== exp_valid || Dout !== exp_data) begin
        errors++;
        $display("FAIL outputs: Dvalid=%b Dout=%h, expected Dvalid=%b Dout=%h",
                 Dvalid, Dout, exp_valid, exp_data);
      end
      checks++;
      if ((int'(parity_err) + int'(frame_err) + int'(overrun)) > 1) begin
        errors++;
        $display("FAIL onehot_err: perr=%b ferr=%b ovr=%b, expected at most one",
                 parity_err, frame_err, overrun);
      end
      if (parity_err) pop_check(K_PERR, 8'h00, "parity_err");
      if (frame_err)  pop_check(K_FERR, 8'h00, "frame_err");
      if (overrun)    pop_check(K_OVR,  8'h00, "overrun");
      if (Dvalid && Dready) pop_check(K_ACC, Dout, "accept");
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, EV_NONE, 8'h00);
    idle(3, 1'b0);

    // Good byte held until consumed
    send_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    // Parity error
    send_frame(8'hA5, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    // Frame error then good 0x3C
    send_frame(8'hA5, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    idle(1, 1'b1);
    // Overrun with one idle bit between frames
    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    // Dready coincident with second stop bit
    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0, 1'b1);
    idle(1, 1'b1);
    idle(2, 1'b0);
    // Load a byte, then reset mid-frame after four data bits
    send_frame(8'h77, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, EV_NONE, 8'h00);
    for (int i = 0; i < 4; i++) cycle(logic'((8'hA5 >> i) & 8'h01), 1'b0, 1'b0, EV_NONE, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, EV_NONE, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, EV_NONE, 8'h00);
    idle(2, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    idle(1, 1'b1);

    for (int n = 0; n < 80; n++) begin
      send_frame(8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(1, 3), 1'b1, 1'b0);
    end
    idle(3, 1'b1);
    idle(2, 1'b0);
    @(posedge clk);
    #1;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, number of payload bits per frame.
REQ-002 SHALL have parameter PARITY_EN, default 1; 1 = even-parity bit present, 0 = no parity bit.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Din  input  1  serial line, one bit per clk, driven by the upstream SISO Dout; idle level 1.
REQ-006 SHALL have port Dout  output  DATA_W  last accepted payload, bit 0 = first data bit received.
REQ-007 SHALL have port Dvalid  output  1  Dout holds an unconsumed byte.
REQ-008 SHALL have port Dready  input  1  consumer accepts Dout when Dvalid & Dready at posedge.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse: frame dropped for bad parity.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: frame dropped for bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: good frame dropped because output register occupied.

Function
REQ-012 Frame format SHALL be: start bit 0, DATA_W data bits LSB first, parity bit (PARITY_EN=1 only), stop bit 1; one bit sampled per posedge, no oversampling.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP, with a bit counter of width clog2(DATA_W).
REQ-014 IDLE: Din=0 -> DATA with counter cleared; Din=1 -> stay IDLE.
REQ-015 DATA: shift Din into payload register at position = counter; after DATA_W-th bit -> PARITY if PARITY_EN else STOP.
REQ-016 PARITY: SHALL store bad-parity flag = (XOR of payload bits) XOR Din; -> STOP.
REQ-017 STOP: always -> IDLE; next start bit is recognised no earlier than the following cycle (one-bit gap minimum between frames).
REQ-018 STOP with Din=0: frame dropped, frame_err pulses the next cycle; parity_err not asserted for this frame.
REQ-019 STOP with Din=1 and bad parity: frame dropped, parity_err pulses the next cycle.
REQ-020 STOP with Din=1, good parity: frame is "good"; if output register free (Dvalid=0, or Dvalid & Dready this cycle), Dout loads payload and Dvalid=1 from the next cycle.
REQ-021 Good frame while Dvalid=1 and Dready=0: new payload dropped, Dout unchanged, overrun pulses the next cycle.
REQ-022 Latency: Dvalid rises exactly one cycle after the posedge sampling the stop bit.
REQ-023 While Dvalid=1 and Dready=0, Dout SHALL remain stable.
REQ-024 Dvalid & Dready with no good frame completing: Dvalid=0 the next cycle.
REQ-025 Dvalid & Dready coincident with good frame completion: Dout loads new payload, Dvalid stays 1, no overrun.
REQ-026 At most one of parity_err, frame_err, overrun SHALL pulse in any cycle.
REQ-027 Dready SHALL be ignored while Dvalid=0.

Reset
REQ-028 rst=1 SHALL immediately force FSM to IDLE, counter 0, Dout=0, Dvalid=0, parity_err=0, frame_err=0, overrun=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no error pulse; after release, decoding restarts at the next Din=0 in IDLE.
REQ-030 Outputs SHALL stay at reset values while rst=1 regardless of Din and Dready.

Verification
REQ-031 Good byte: Din idle 1, then 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1), Dready=0 -> Dvalid=1 one cycle after stop, Dout=8'hA5, held until Dready=1, then Dvalid=0 next cycle.
REQ-032 Parity error: same stream with parity bit 1 -> parity_err one pulse, Dvalid stays 0, Dout unchanged.
REQ-033 Frame error: 0xA5 with stop bit 0 -> frame_err one pulse, no Dvalid; a following good 0x3C frame (parity 0) -> Dout=8'h3C.
REQ-034 Overrun: 0xA5 then 0x5A back-to-back with one idle bit, Dready=0 throughout -> Dout=8'hA5 retained, overrun one pulse after second stop bit.
REQ-035 Simultaneous: Dready=1 on exactly the cycle the second frame (0x5A) stop bit is sampled -> Dvalid stays 1, Dout=8'h5A, no overrun.
REQ-036 Reset mid-frame: rst pulsed after 4 data bits of 0xA5 -> all outputs 0, no error pulse; a full 0xC3 frame (parity 0) after release -> Dout=8'hC3, Dvalid=1.
